// File: rtl/int_arbiter_pkg.sv
// Interrupt arbiter shared types and constants.
// Also used by the control unit's interrupt decode.
package int_arbiter_pkg;

    localparam int INTC_INTS_BIT = 3;

    typedef enum logic [1:0] {
        INTC_ST_IDLE = 2'd0,
        INTC_ST_REQ  = 2'd1,
        INTC_ST_HOLD = 2'd2
    } intc_st_e;

    localparam logic [INTC_INTS_BIT-1:0] INTS_NONE = 3'd0;
    localparam logic [INTC_INTS_BIT-1:0] INTS_SRC0 = 3'd1;
    localparam logic [INTC_INTS_BIT-1:0] INTS_SRC1 = 3'd2;
    localparam logic [INTC_INTS_BIT-1:0] INTS_SRC2 = 3'd3;

    // ints code to the irs bit the control unit sets on entry
    function automatic logic [2:0] ints_irs_mask(
        input logic [INTC_INTS_BIT-1:0] code
    );
        case (code)
            INTS_SRC0: ints_irs_mask = 3'b001;
            INTS_SRC1: ints_irs_mask = 3'b010;
            INTS_SRC2: ints_irs_mask = 3'b100;
            default:   ints_irs_mask = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/int_arbiter_if.sv
// Interrupt arbiter bundle between CP0/pipeline and the arbiter.
// master = core side, slave = arbiter.
interface int_arbiter_if #(
    parameter int N_SRC = 3
);
    import int_arbiter_pkg::*;

    logic [N_SRC-1:0]         irq_in;
    logic                     ie;
    logic [N_SRC-1:0]         irs;
    logic                     int_ack;
    logic                     int_req;
    logic [INTC_INTS_BIT-1:0] ints;
    logic [N_SRC-1:0]         pending;

    modport master (
        output irq_in, ie, irs, int_ack,
        input  int_req, ints, pending
    );

    modport slave (
        input  irq_in, ie, irs, int_ack,
        output int_req, ints, pending
    );

endinterface

// File: rtl/int_arbiter_sync.sv
// Per-source synchroniser and rising-edge detector.
// Edges are suppressed until the chain holds post-reset samples.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic [SYNC_STAGES:0]   vld_q;

    // Synchronise, delay one cycle, and track which flops hold real samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            vld_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
            dly_q  <= sync_q[SYNC_STAGES-1];
            vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // A level held through reset must not look like a fresh edge
    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q & vld_q[SYNC_STAGES];

endmodule

// File: rtl/int_arbiter.sv
// Fixed-priority interrupt arbiter for the CP0 interrupt path.
// Latches edges as pending, grants one source and holds it until accepted.
module int_arbiter
    import int_arbiter_pkg::*;
#(
    parameter int N_SRC       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 2
) (
    input logic           clk,
    input logic           rst_n,
    int_arbiter_if.slave  bus
);

    localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

    logic [N_SRC-1:0]         edges;
    logic [N_SRC-1:0]         pending_q, pending_d;
    logic [N_SRC-1:0]         elig;
    logic [N_SRC-1:0]         clr_mask;
    logic                     blk;
    logic [INTC_INTS_BIT-1:0] grant;

    intc_st_e                 state_q, state_d;
    logic                     int_q, int_d;
    logic [INTC_INTS_BIT-1:0] ints_q, ints_d;
    logic [CW-1:0]            cnt_q, cnt_d;

    for (genvar s = 0; s < N_SRC; s++) begin : g_sync
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .irq_in (bus.irq_in[s]),
            .rise   (edges[s])
        );
    end

    // Eligibility masks by ie and by equal-or-higher in-service; highest index wins
    always_comb begin
        blk   = 1'b0;
        elig  = '0;
        grant = INTS_NONE;
        for (int s = N_SRC - 1; s >= 0; s--) begin
            blk     = blk | bus.irs[s];
            elig[s] = pending_q[s] & bus.ie & ~blk;
        end
        for (int s = 0; s < N_SRC; s++) begin
            if (elig[s]) grant = INTC_INTS_BIT'(s + 1);
        end
    end

    // Next state, registered outputs and pending clear on accept
    always_comb begin
        state_d  = state_q;
        int_d    = int_q;
        ints_d   = ints_q;
        cnt_d    = cnt_q;
        clr_mask = '0;
        unique case (state_q)
            INTC_ST_IDLE: begin
                if (|elig) begin
                    int_d   = 1'b1;
                    ints_d  = grant;
                    state_d = INTC_ST_REQ;
                end
            end
            INTC_ST_REQ: begin
                if (bus.int_ack) begin
                    clr_mask = N_SRC'(1) << (ints_q - 3'd1);
                    int_d    = 1'b0;
                    ints_d   = INTS_NONE;
                    cnt_d    = CW'(HOLDOFF);
                    state_d  = INTC_ST_HOLD;
                end else if (!bus.ie) begin
                    int_d    = 1'b0;
                    ints_d   = INTS_NONE;
                    state_d  = INTC_ST_IDLE;
                end
            end
            INTC_ST_HOLD: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = INTC_ST_IDLE;
                end
            end
            default: state_d = INTC_ST_IDLE;
        endcase
        // a new edge on the accepted source in the same cycle survives
        pending_d = (pending_q & ~clr_mask) | edges;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= INTC_ST_IDLE;
            int_q     <= 1'b0;
            ints_q    <= INTS_NONE;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            int_q     <= int_d;
            ints_q    <= ints_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign bus.int_req = int_q;
    assign bus.ints    = ints_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Directed bench for int_arbiter.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_int_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    int_arbiter_if #(.N_SRC(3)) bus ();

    int_arbiter #(
        .N_SRC       (3),
        .SYNC_STAGES (2),
        .HOLDOFF     (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.irq_in  = 3'b000;
        bus.ie      = 1'b0;
        bus.irs     = 3'b000;
        bus.int_ack = 1'b0;
        tick(2);
        check("rst_int", 8'(bus.int_req), 8'h0);
        check("rst_ints", 8'(bus.ints), 8'h0);
        check("rst_pend", 8'(bus.pending), 8'h0);
        rst_n  = 1'b1;
        bus.ie = 1'b1;
        tick(4);

        // 1: single source, latency and accept
        bus.irq_in = 3'b001;
        tick(3);
        check("t1_pend_set", 8'(bus.pending), 8'h1);
        check("t1_int_early", 8'(bus.int_req), 8'h0);
        tick(1);
        check("t1_int", 8'(bus.int_req), 8'h1);
        check("t1_ints", 8'(bus.ints), 8'h1);
        bus.int_ack = 1'b1;
        bus.irq_in  = 3'b000;
        tick(1);
        bus.int_ack = 1'b0;
        check("t1_ack_int", 8'(bus.int_req), 8'h0);
        check("t1_ack_ints", 8'(bus.ints), 8'h0);
        check("t1_ack_pend", 8'(bus.pending), 8'h0);
        tick(3);

        // 2: simultaneous src0/src2, priority then irs masking
        bus.irq_in = 3'b101;
        tick(4);
        check("t2_int", 8'(bus.int_req), 8'h1);
        check("t2_ints_hi", 8'(bus.ints), 8'h3);
        check("t2_pend", 8'(bus.pending), 8'h5);
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0;
        bus.irs     = 3'b100;
        bus.irq_in  = 3'b000;
        check("t2_ack_pend", 8'(bus.pending), 8'h1);
        tick(4);
        check("t2_masked_int", 8'(bus.int_req), 8'h0);
        check("t2_masked_pend", 8'(bus.pending), 8'h1);
        bus.irs = 3'b000;
        tick(1);
        check("t2_lo_int", 8'(bus.int_req), 8'h1);
        check("t2_lo_ints", 8'(bus.ints), 8'h1);
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0;
        check("t2_lo_ack", 8'(bus.pending), 8'h0);
        tick(3);

        // 3: nesting over lower in-service, blocked by equal
        bus.irs    = 3'b001;
        bus.irq_in = 3'b010;
        tick(4);
        check("t3_nest_int", 8'(bus.int_req), 8'h1);
        check("t3_nest_ints", 8'(bus.ints), 8'h2);
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0;
        bus.irq_in  = 3'b000;
        tick(3);
        bus.irs    = 3'b010;
        bus.irq_in = 3'b010;
        tick(5);
        check("t3_blk_int", 8'(bus.int_req), 8'h0);
        check("t3_blk_pend", 8'(bus.pending), 8'h2);
        bus.irs = 3'b000;
        tick(1);
        check("t3_rel_ints", 8'(bus.ints), 8'h2);
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0;
        bus.irq_in  = 3'b000;
        tick(3);

        // 4: ie low holds off the request
        bus.ie     = 1'b0;
        bus.irq_in = 3'b100;
        tick(4);
        check("t4_pend", 8'(bus.pending), 8'h4);
        check("t4_int_off", 8'(bus.int_req), 8'h0);
        bus.ie = 1'b1;
        tick(1);
        check("t4_int", 8'(bus.int_req), 8'h1);
        check("t4_ints", 8'(bus.ints), 8'h3);

        // 5: withdraw on ie drop, then re-request
        bus.ie = 1'b0;
        tick(1);
        check("t5_wd_int", 8'(bus.int_req), 8'h0);
        check("t5_wd_ints", 8'(bus.ints), 8'h0);
        check("t5_wd_pend", 8'(bus.pending), 8'h4);
        bus.ie = 1'b1;
        tick(1);
        check("t5_re_int", 8'(bus.int_req), 8'h1);
        check("t5_re_ints", 8'(bus.ints), 8'h3);
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0;
        bus.irq_in  = 3'b000;
        check("t5_ack_pend", 8'(bus.pending), 8'h0);
        tick(3);

        // 6: reset while in REQ with held levels
        bus.irq_in = 3'b011;
        tick(4);
        check("t6_pend", 8'(bus.pending), 8'h3);
        check("t6_ints", 8'(bus.ints), 8'h2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("t6_rst_int", 8'(bus.int_req), 8'h0);
        check("t6_rst_ints", 8'(bus.ints), 8'h0);
        check("t6_rst_pend", 8'(bus.pending), 8'h0);
        tick(6);
        check("t6_nocap_pend", 8'(bus.pending), 8'h0);
        check("t6_nocap_int", 8'(bus.int_req), 8'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
